// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C SCL generator: state encoding, default
// divisor width and minimum quarter-period.
package i2c_pkg;

    localparam int unsigned I2C_CNT_W = 16;
    localparam int unsigned I2C_MIN_Q = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW1  = 3'd1,
        LOW2  = 3'd2,
        HIGH1 = 3'd3,
        HIGH2 = 3'd4
    } scl_state_t;

    // SCL level driven in each state; only the two low phases pull the line.
    function automatic logic state_scl(input scl_state_t s);
        return !((s == LOW1) || (s == LOW2));
    endfunction

endpackage

// File: rtl/i2c_phase_counter.sv
// Phase counter: counts 0..q-1 and pulses tc in the last cycle of a phase,
// wrapping to 0; restart forces 0, hold freezes the count.
module i2c_phase_counter
    import i2c_pkg::*;
#(
    parameter int unsigned CNT_W = I2C_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             restart,
    input  logic             hold,
    input  logic [CNT_W-1:0] q,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last;

    // q is never below 1, so q-1 cannot underflow.
    assign last = q - CNT_W'(1);
    assign tc   = !restart && !hold && (cnt_q == last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (restart || tc) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator with four single-cycle phase strobes.
// Optional slave clock stretching in HIGH1 when I2C_SCL_STRETCH_EN is defined.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int unsigned CNT_W = I2C_CNT_W,
    parameter int unsigned MIN_Q = I2C_MIN_Q
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_q,
    input  logic             scl_i,
    output logic             scl_o,
    output logic             tick_fall,
    output logic             tick_mid_low,
    output logic             tick_rise,
    output logic             tick_mid_high,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MIN_Q_C = CNT_W'(MIN_Q);

    scl_state_t       state_q, state_d;
    logic [CNT_W-1:0] eff_q, q_lat;
    logic             tc, hold, restart, enter;
    logic             fall_d, mid_low_d, rise_d, mid_high_d;

    assign eff_q   = (div_q < MIN_Q_C) ? MIN_Q_C : div_q;
    assign restart = (state_q == IDLE);

`ifdef I2C_SCL_STRETCH_EN
    assign hold = (state_q == HIGH1) && !scl_i;
`else
    logic unused_scl_i;
    assign hold         = 1'b0;
    assign unused_scl_i = scl_i;
`endif

    i2c_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (restart),
        .hold    (hold),
        .q       (q_lat),
        .tc      (tc)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = LOW1;
            LOW1:    if (tc) state_d = LOW2;
            LOW2:    if (tc) state_d = HIGH1;
            HIGH1:   if (tc) state_d = HIGH2;
            HIGH2:   if (tc) state_d = en ? LOW1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every transition changes state, so a state change marks a phase start.
    always_comb begin
        enter      = (state_d != state_q);
        fall_d     = enter && (state_d == LOW1);
        mid_low_d  = enter && (state_d == LOW2);
        rise_d     = enter && (state_d == HIGH1);
        mid_high_d = enter && (state_d == HIGH2);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_lat         <= MIN_Q_C;
            scl_o         <= 1'b1;
            tick_fall     <= 1'b0;
            tick_mid_low  <= 1'b0;
            tick_rise     <= 1'b0;
            tick_mid_high <= 1'b0;
            busy          <= 1'b0;
        end else begin
            if (fall_d) begin
                q_lat <= eff_q;
            end
            scl_o         <= state_scl(state_d);
            tick_fall     <= fall_d;
            tick_mid_low  <= mid_low_d;
            tick_rise     <= rise_d;
            tick_mid_high <= mid_high_d;
            busy          <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed self-checking bench for i2c_scl_gen (4-bit divisor instance).
// Stretch expectations follow I2C_SCL_STRETCH_EN when defined.
module tb_i2c_scl_gen;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] div_q = 4'd0;
    logic       scl_i = 1'b1;
    logic       scl_o, tick_fall, tick_mid_low, tick_rise, tick_mid_high, busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int mh_cyc = -1;
    int rise_cyc = 0;

    always #5 clk = ~clk;

    i2c_scl_gen #(
        .CNT_W (4),
        .MIN_Q (1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .div_q         (div_q),
        .scl_i         (scl_i),
        .scl_o         (scl_o),
        .tick_fall     (tick_fall),
        .tick_mid_low  (tick_mid_low),
        .tick_rise     (tick_rise),
        .tick_mid_high (tick_mid_high),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tick_mid_high && mh_cyc < 0) mh_cyc = cyc;
        chk("onehot_ticks",
            32'(($countones({tick_fall, tick_mid_low, tick_rise, tick_mid_high}) <= 1)), 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_scl"}, 32'(scl_o), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ticks"}, 32'({tick_fall, tick_mid_low, tick_rise, tick_mid_high}), 0);
    endtask

    // Offset k counts cycles from the first LOW1 cycle of a period of quarter q.
    task automatic run_check(input int q, input int k0, input int k1);
        int p, ph;
        logic first;
        for (int k = k0; k < k1; k++) begin
            tick();
            p     = k % (4 * q);
            ph    = p / q;
            first = ((p % q) == 0);
            chk($sformatf("q%0d_k%0d_scl", q, k), 32'(scl_o), 32'(ph >= 2));
            chk($sformatf("q%0d_k%0d_busy", q, k), 32'(busy), 1);
            chk($sformatf("q%0d_k%0d_ticks", q, k),
                32'({tick_fall, tick_mid_low, tick_rise, tick_mid_high}),
                32'({first && ph == 0, first && ph == 1, first && ph == 2, first && ph == 3}));
        end
    endtask

    // Holds reset for a cycle with en=1, then releases; the next sample is offset 0.
    task automatic start(input logic [3:0] q);
        @(negedge clk);
        reset_n = 1'b0;
        en      = 1'b1;
        div_q   = q;
        scl_i   = 1'b1;
        #1;
        chk_idle("reset_async");
        @(negedge clk);
        chk_idle("reset_held");
        reset_n = 1'b1;
    endtask

    initial begin
        // Q=4: ticks at 0/4/8/12, period 16, high for 8 cycles; two periods.
        start(4'd4);
        run_check(4, 0, 32);

        // Clamp to MIN_Q: div_q=0 and div_q=1 both give a 4-cycle period.
        start(4'd0);
        run_check(1, 0, 8);
        start(4'd1);
        run_check(1, 0, 8);

        // Largest divisor for the 4-bit instance.
        start(4'd15);
        run_check(15, 0, 64);

        // en dropped in the first LOW2 cycle of a Q=3 run: period completes, then idle.
        start(4'd3);
        run_check(3, 0, 4);
        en = 1'b0;
        run_check(3, 4, 12);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle($sformatf("stop_idle%0d", i));
        end

        // div_q 4->2 during LOW1: current period stays 16, next is 8.
        start(4'd4);
        run_check(4, 0, 2);
        div_q = 4'd2;
        run_check(4, 2, 16);
        run_check(2, 0, 8);

        // Reset pulsed in the first HIGH1 cycle clears outputs asynchronously.
        start(4'd4);
        run_check(4, 0, 9);
        reset_n = 1'b0;
        en      = 1'b0;
        #1;
        chk_idle("hi1_reset_async");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk_idle("post_reset0");
        tick();
        chk_idle("post_reset1");
        en = 1'b1;
        run_check(4, 0, 4);

        // Stretch: scl_i low through the first 5 HIGH1 cycles, Q=2.
        start(4'd2);
        run_check(2, 0, 4);
        scl_i  = 1'b0;
        mh_cyc = -1;
        tick();
        rise_cyc = cyc;
        chk("stretch_rise", 32'(tick_rise), 1);
        repeat (5) tick();
        scl_i = 1'b1;
        repeat (6) tick();
`ifdef I2C_SCL_STRETCH_EN
        chk("stretch_mid_high_delay", 32'(mh_cyc - rise_cyc), 7);
`else
        chk("stretch_mid_high_delay", 32'(mh_cyc - rise_cyc), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
